// File: rtl/dice_pkg.sv
// Shared types and constants for the die sampler: FSM states, side limits,
// default timeout and the sides-to-bit-width helper.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam int MIN_SIDES          = 2;
    localparam int MAX_SIDES_DEF      = 20;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Minimum number of bits needed to hold sides-1 (never less than one).
    function automatic logic [2:0] sides_to_k(input logic [4:0] sides);
        logic [4:0] m;
        logic [2:0] k;
        m = sides - 5'd1;
        k = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (m[i]) k = 3'(i + 1);
        end
        return k;
    endfunction

endpackage

// File: rtl/die_sampler_if.sv
// Roll request/result signals plus the single-bit RNG handshake, grouped so the
// sampler and its environment see one bundle. dbg_state mirrors the sampler FSM.
interface die_sampler_if;
    import dice_pkg::*;

    // Handshake: roll is only looked at while busy=0; valid/error are one-cycle
    // pulses; rng_start asks for one bit and rng_done marks rng_result for one cycle.
    logic       roll;
    logic [4:0] sides;
    logic [4:0] value;
    logic       valid;
    logic       busy;
    logic       error;
    logic       rng_start;
    logic       rng_result;
    logic       rng_done;
    state_t     dbg_state;

    modport slave (
        input  roll, sides, rng_result, rng_done,
        output value, valid, busy, error, rng_start, dbg_state
    );

    modport master (
        output roll, sides, rng_result, rng_done,
        input  value, valid, busy, error, rng_start, dbg_state
    );

endinterface

// File: rtl/rng_bit_fetch.sv
// Drives the one-bit RNG request and watches for its answer, raising a bit
// strobe on rng_done or a timeout strobe after TIMEOUT_CYCLES silent WAIT cycles.
module rng_bit_fetch
    import dice_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_req,
    input  logic in_wait,
    input  logic rng_done,
    input  logic rng_result,
    output logic rng_start,
    output logic bit_strobe,
    output logic bit_value,
    output logic timeout_strobe
);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // The counter sits at zero outside WAIT, so every WAIT entry starts fresh.
    always_comb begin
        rng_start      = in_req;
        bit_strobe     = in_wait & rng_done;
        bit_value      = rng_result;
        timeout_strobe = in_wait & ~rng_done & (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
        wait_cnt_d     = in_wait ? (wait_cnt_q + 8'd1) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/die_sampler.sv
// Uniform die roller: gathers k random bits MSB-first per attempt and rejects
// candidates >= sides until one fits, then reports candidate+1.
module die_sampler
    import dice_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int MAX_SIDES      = MAX_SIDES_DEF
) (
    input logic          clk,
    input logic          reset_n,
    die_sampler_if.slave bus
);

    state_t     state_q, state_d;
    logic [4:0] sides_q, sides_d;
    logic [2:0] k_q, k_d;
    logic [4:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;

    logic       bit_strobe;
    logic       bit_value;
    logic       timeout_strobe;
    logic       sides_legal;
    logic [4:0] cand;

    rng_bit_fetch #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fetch (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_req        (state_q == ST_REQ),
        .in_wait       (state_q == ST_WAIT),
        .rng_done      (bus.rng_done),
        .rng_result    (bus.rng_result),
        .rng_start     (bus.rng_start),
        .bit_strobe    (bit_strobe),
        .bit_value     (bit_value),
        .timeout_strobe(timeout_strobe)
    );

    assign sides_legal = (bus.sides >= 5'(MIN_SIDES)) && (bus.sides <= 5'(MAX_SIDES));
    // Mask to the low k bits; k=5 wraps the shifted one to zero, giving all ones.
    assign cand = shreg_q & ((5'd1 << k_q) - 5'd1);

    always_comb begin
        state_d = state_q;
        sides_d = sides_q;
        k_d     = k_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.roll) begin
                    if (sides_legal) begin
                        sides_d = bus.sides;
                        k_d     = sides_to_k(bus.sides);
                        shreg_d = 5'd0;
                        cnt_d   = 3'd0;
                        state_d = ST_REQ;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bit_strobe) begin
                    shreg_d = {shreg_q[3:0], bit_value};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = ((cnt_q + 3'd1) == k_q) ? ST_CHECK : ST_REQ;
                end else if (timeout_strobe) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cand < sides_q) begin
                    value_d = cand + 5'd1;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = 5'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sides_q <= 5'd0;
            k_q     <= 3'd0;
            shreg_q <= 5'd0;
            cnt_q   <= 3'd0;
            value_q <= 5'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sides_q <= sides_d;
            k_q     <= k_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.error     = error_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_die_sampler.sv
// Bench for die_sampler: directed rolls with hand-computed results, a per-cycle
// compare process against a rejection-sampling model, and a random-RNG run.
module tb_die_sampler;
    import dice_pkg::*;

    localparam int MAX_SIDES = 20;
    localparam int N_RAND    = 3000;

    logic clk;
    logic reset_n;

    die_sampler_if bus ();

    die_sampler dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int         n_checks;
    int         n_errors;
    bit         chk_en;
    bit         in_roll;
    bit         illegal_pending;
    bit         start_seen;
    bit         rng_responsive;
    bit         force_done;
    bit         allow_timeout;
    int         roll_sides;
    int         roll_starts;
    int         n_valid;
    int         timeouts;
    int         hist[32];
    logic [4:0] last_value;
    bit         roll_bits[$];
    bit         bit_q[$];
    logic [4:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Rejection sampling on the delivered bit stream: k = smallest width with
    // 2^k >= sides, take k bits MSB-first, accept the first chunk below sides.
    function automatic void model_roll(output int val, output int used);
        int k;
        int c;
        k = 0;
        while ((1 << k) < roll_sides) k++;
        if (k == 0) k = 1;
        val  = 0;
        used = -1;
        for (int p = 0; p + k <= roll_bits.size(); p += k) begin
            c = 0;
            for (int j = 0; j < k; j++) c = c * 2 + int'(roll_bits[p+j]);
            if (c < roll_sides) begin
                val  = c + 1;
                used = p + k;
                break;
            end
        end
    endfunction

    // ---------------- RNG responder ----------------
    always @(posedge clk) begin
        bit b;
        #1;
        if ((rng_responsive && start_seen) || force_done) begin
            b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'($urandom_range(0, 1));
            bus.rng_done   = 1'b1;
            bus.rng_result = b;
            if (in_roll && !force_done) roll_bits.push_back(b);
        end else begin
            bus.rng_done   = 1'b0;
            bus.rng_result = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int ev;
        int eu;
        if (chk_en) begin
            check("valid_error_excl", int'(bus.valid && bus.error), 0);
            check("start_not_back_to_back", int'(bus.rng_start && start_seen), 0);
            if (bus.rng_start) begin
                check("start_only_in_roll", int'(in_roll), 1);
                roll_starts++;
            end
            if (bus.valid) begin
                check("valid_in_roll", int'(in_roll), 1);
                model_roll(ev, eu);
                check("value_vs_model", bus.value, ev);
                check("bits_used", roll_bits.size(), eu);
                check("start_count", roll_starts, roll_bits.size());
                if (exp_q.size() > 0) check("value_literal", bus.value, exp_q.pop_front());
                hist[bus.value]++;
                n_valid++;
                last_value = bus.value;
                in_roll = 1'b0;
            end else begin
                check("value_hold", bus.value, last_value);
            end
            if (illegal_pending) begin
                check("illegal_sides_error", int'(bus.error), 1);
            end else if (bus.error) begin
                if (in_roll && allow_timeout) begin
                    timeouts++;
                    in_roll = 1'b0;
                end else begin
                    check("unexpected_error", int'(bus.error), 0);
                end
            end
            check("busy", int'(bus.busy), int'(in_roll));
            // Predict what the coming rising edge does.
            illegal_pending = 1'b0;
            if (!reset_n) begin
                in_roll    = 1'b0;
                last_value = 5'd0;
                roll_bits.delete();
            end else if (!bus.busy && bus.roll) begin
                if (bus.sides >= 5'd2 && bus.sides <= 5'(MAX_SIDES)) begin
                    in_roll     = 1'b1;
                    roll_sides  = int'(bus.sides);
                    roll_starts = 0;
                    roll_bits.delete();
                end else begin
                    illegal_pending = 1'b1;
                end
            end
        end
        start_seen = bus.rng_start;
    end

    // ---------------- driver tasks ----------------
    task automatic run_roll(input string name, input int s, input int exp_val,
                            input int exp_starts, input int exp_edges);
        int edges;
        int starts;
        bit got;
        exp_q.push_back(5'(exp_val));
        @(posedge clk); #1;
        bus.roll  = 1'b1;
        bus.sides = 5'(s);
        @(posedge clk); #1;
        bus.roll = 1'b0;
        edges  = 0;
        starts = 0;
        got    = 1'b0;
        while (edges < 300) begin
            if (bus.rng_start) starts++;
            if (bus.valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        check({name, "_valid_seen"}, int'(got), 1);
        check({name, "_value"}, bus.value, exp_val);
        check({name, "_starts"}, starts, exp_starts);
        check({name, "_latency_edges"}, edges, exp_edges);
        check({name, "_busy_at_valid"}, int'(bus.busy), 0);
    endtask

    task automatic run_illegal(input string name, input int s);
        @(posedge clk); #1;
        bus.roll  = 1'b1;
        bus.sides = 5'(s);
        @(posedge clk); #1;
        bus.roll = 1'b0;
        check({name, "_error"}, int'(bus.error), 1);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_start"}, int'(bus.rng_start), 0);
        @(posedge clk); #1;
        check({name, "_error_one_cycle"}, int'(bus.error), 0);
        check({name, "_start_after"}, int'(bus.rng_start), 0);
        check({name, "_busy_after"}, int'(bus.busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int edges;
        bit got;
        int cyc;
        int lo;
        int hi;
        n_checks       = 0;
        n_errors       = 0;
        chk_en         = 1'b0;
        in_roll        = 1'b0;
        rng_responsive = 1'b1;
        force_done     = 1'b0;
        allow_timeout  = 1'b0;
        last_value     = 5'd0;
        n_valid        = 0;
        timeouts       = 0;
        for (int i = 0; i < 32; i++) hist[i] = 0;
        reset_n        = 1'b0;
        bus.roll       = 1'b0;
        bus.sides      = 5'd0;
        bus.rng_done   = 1'b0;
        bus.rng_result = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        check("reset_value", bus.value, 0);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_error", int'(bus.error), 0);
        check("reset_rng_start", int'(bus.rng_start), 0);

        // sides=4: bits 0,1 -> candidate 1 -> value 2, valid after edge 5.
        bit_q = '{1'b0, 1'b1};
        run_roll("d4", 4, 2, 2, 5);
        // sides=6: 111 = 7 rejected, 010 = 2 accepted -> value 3.
        bit_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        run_roll("d6_reject", 6, 3, 6, 14);
        // sides=2: single bit 1 -> value 2.
        bit_q = '{1'b1};
        run_roll("d2", 2, 2, 1, 3);
        // sides=20: 10100 = 20 rejected (equal to sides), 10011 = 19 -> value 20.
        bit_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_roll("d20_edge", 20, 20, 10, 22);

        run_illegal("sides1", 1);
        run_illegal("sides21", 21);
        run_illegal("sides0", 0);

        // RNG never answers: abort after 255 WAIT cycles, value kept.
        rng_responsive = 1'b0;
        allow_timeout  = 1'b1;
        @(posedge clk); #1;
        bus.roll  = 1'b1;
        bus.sides = 5'd4;
        @(posedge clk); #1;
        bus.roll = 1'b0;
        edges = 0;
        got   = 1'b0;
        while (edges < 400) begin
            if (bus.error) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("timeout_seen", int'(got), 1);
        check("timeout_edges", edges, 256);
        check("timeout_busy", int'(bus.busy), 0);
        check("timeout_value_kept", bus.value, 20);
        check("timeout_no_valid", int'(bus.valid), 0);
        @(posedge clk); #1;
        check("timeout_error_one_cycle", int'(bus.error), 0);
        check("timeout_count", timeouts, 1);
        allow_timeout  = 1'b0;

        // Reset during WAIT, then a stray rng_done: nothing may come out.
        @(posedge clk); #1;
        bus.roll  = 1'b1;
        bus.sides = 5'd4;
        @(posedge clk); #1;
        bus.roll = 1'b0;
        @(posedge clk); #1;
        check("rst_state_wait", int'(bus.dbg_state), int'(ST_WAIT));
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_value", bus.value, 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_error", int'(bus.error), 0);
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("late_done_busy", int'(bus.busy), 0);
        check("late_done_valid", int'(bus.valid), 0);
        check("late_done_start", int'(bus.rng_start), 0);
        rng_responsive = 1'b1;
        bit_q = '{1'b0, 1'b1};
        run_roll("after_reset", 4, 2, 2, 5);

        // Random bits, roll held high, sides scrambled while busy.
        for (int i = 0; i < 32; i++) hist[i] = 0;
        n_valid = 0;
        @(posedge clk); #1;
        bus.sides = 5'd20;
        bus.roll  = 1'b1;
        cyc = 0;
        while (n_valid < N_RAND && cyc < 90000) begin
            @(posedge clk); #1;
            cyc++;
            bus.sides = bus.busy ? 5'($urandom_range(0, 31)) : 5'd20;
        end
        bus.roll = 1'b0;
        check("rand_roll_count", n_valid, N_RAND);
        cyc = 0;
        while (bus.busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_drain_idle", int'(bus.busy), 0);
        lo = (n_valid * 70) / (100 * MAX_SIDES);
        hi = (n_valid * 130) / (100 * MAX_SIDES);
        check("rand_bucket_0_empty", hist[0], 0);
        for (int v = 1; v <= MAX_SIDES; v++) begin
            if (hist[v] < lo || hist[v] > hi) begin
                check($sformatf("rand_bucket_%0d_count_in_%0d_%0d", v, lo, hi), hist[v], (lo + hi) / 2);
            end else begin
                check($sformatf("rand_bucket_%0d_in_range", v), 1, 1 - int'(hist[v] < lo || hist[v] > hi));
            end
        end
        for (int v = MAX_SIDES + 1; v < 32; v++) check($sformatf("rand_bucket_%0d_empty", v), hist[v], 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
